// File: rtl/acceptance_filter_config_if.sv
// Register-access bus of the acceptance filter configuration block.
// Strobes are single-cycle. The DUT answers each write with exactly one o_wr_ack or o_wr_err pulse and each read with one o_rd_valid pulse.
interface acceptance_filter_config_if;
  logic        i_wr_en;
  logic [3:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        o_wr_ack;
  logic        o_wr_err;
  logic        i_rd_en;
  logic [3:0]  i_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_valid;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
    input  o_wr_ack, o_wr_err, o_rd_data, o_rd_valid
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
    output o_wr_ack, o_wr_err, o_rd_data, o_rd_valid
  );
endinterface

// File: rtl/acceptance_filter_config.sv
// Holds the mask/ID registers and filter-pair enables for the acceptance filter.
// A UAF update waits for the filter to go idle, is applied, and then settles before the write is acknowledged.
module acceptance_filter_config #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                        i_sys_clk,
  input  logic                        i_reset,
  acceptance_filter_config_if.slave   bus,
  input  logic                        i_filter_busy,
  output logic [31:0]                 o_afmr1,
  output logic [31:0]                 o_afmr2,
  output logic [31:0]                 o_afmr3,
  output logic [31:0]                 o_afmr4,
  output logic [31:0]                 o_afir1,
  output logic [31:0]                 o_afir2,
  output logic [31:0]                 o_afir3,
  output logic [31:0]                 o_afir4,
  output logic                        o_uaf1,
  output logic                        o_uaf2,
  output logic                        o_uaf3,
  output logic                        o_uaf4,
  output logic                        o_acfbsy,
  output logic [1:0]                  o_fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FLT = 2'd1,
    APPLY    = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] afmr [4];
  logic [31:0] afir [4];
  logic [3:0]  uaf;
  logic [3:0]  pending;
  logic [3:0]  cnt;
  logic [1:0]  wr_idx;
  logic        wr_is_mask;
  logic        wr_is_id;
  logic        accept_reg;
  logic        accept_afr;
  logic        err_req;
  logic        done;
  logic        ack_req;
  logic        err_pend;
  logic [31:0] rd_mux;

  always_comb begin
    wr_idx = 2'd0;
    case (bus.i_wr_addr)
      4'd1, 4'd5: wr_idx = 2'd0;
      4'd2, 4'd6: wr_idx = 2'd1;
      4'd3, 4'd7: wr_idx = 2'd2;
      4'd4, 4'd8: wr_idx = 2'd3;
      default:    wr_idx = 2'd0;
    endcase
    wr_is_mask = (bus.i_wr_addr >= 4'd1) && (bus.i_wr_addr <= 4'd4);
    wr_is_id   = (bus.i_wr_addr >= 4'd5) && (bus.i_wr_addr <= 4'd8);
    // A mask/ID pair may only be rewritten while its filter pair is disabled.
    accept_reg = bus.i_wr_en && (state == IDLE) && (wr_is_mask || wr_is_id) && !uaf[wr_idx];
    accept_afr = bus.i_wr_en && (state == IDLE) && (bus.i_wr_addr == 4'd0);
    err_req    = bus.i_wr_en && !accept_reg && !accept_afr;
    done       = (state == SETTLE) && (cnt == 4'd1);
    ack_req    = accept_reg || done;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept_afr) next_state = WAIT_FLT;
      WAIT_FLT: if (!i_filter_busy) next_state = APPLY;
      APPLY:    next_state = SETTLE;
      SETTLE:   if (cnt == 4'd1) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (bus.i_rd_addr)
      4'd0:    rd_mux = {28'd0, uaf};
      4'd1:    rd_mux = afmr[0];
      4'd2:    rd_mux = afmr[1];
      4'd3:    rd_mux = afmr[2];
      4'd4:    rd_mux = afmr[3];
      4'd5:    rd_mux = afir[0];
      4'd6:    rd_mux = afir[1];
      4'd7:    rd_mux = afir[2];
      4'd8:    rd_mux = afir[3];
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) begin
        afmr[i] <= 32'd0;
        afir[i] <= 32'd0;
      end
      uaf            <= 4'd0;
      pending        <= 4'd0;
      cnt            <= 4'd0;
      bus.o_wr_ack   <= 1'b0;
      bus.o_wr_err   <= 1'b0;
      err_pend       <= 1'b0;
      bus.o_rd_valid <= 1'b0;
      bus.o_rd_data  <= 32'd0;
    end else begin
      if (accept_reg) begin
        if (wr_is_mask) afmr[wr_idx] <= bus.i_wr_data;
        else            afir[wr_idx] <= bus.i_wr_data;
      end
      if (accept_afr) pending <= bus.i_wr_data[3:0];
      if (state == APPLY) begin
        uaf <= pending;
        cnt <= 4'(SETTLE_CYCLES);
      end else if (state == SETTLE) begin
        cnt <= cnt - 4'd1;
      end
      // A write rejected on the completion edge has its error held back one cycle so ack and err never overlap.
      bus.o_wr_ack   <= ack_req;
      bus.o_wr_err   <= !ack_req && (err_req || err_pend);
      err_pend       <= ack_req && (err_req || err_pend);
      bus.o_rd_valid <= bus.i_rd_en;
      if (bus.i_rd_en) bus.o_rd_data <= rd_mux;
    end
  end

  assign o_afmr1     = afmr[0];
  assign o_afmr2     = afmr[1];
  assign o_afmr3     = afmr[2];
  assign o_afmr4     = afmr[3];
  assign o_afir1     = afir[0];
  assign o_afir2     = afir[1];
  assign o_afir3     = afir[2];
  assign o_afir4     = afir[3];
  assign o_uaf1      = uaf[0];
  assign o_uaf2      = uaf[1];
  assign o_uaf3      = uaf[2];
  assign o_uaf4      = uaf[3];
  assign o_acfbsy    = (state != IDLE);
  assign o_fsm_state = state;

endmodule

// File: tb/tb_acceptance_filter_config.sv
// Directed bench for acceptance_filter_config: register writes, UAF update sequence, locking, reads and reset abort.
module tb_acceptance_filter_config;

  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_APPLY = 2'd2, S_SETTLE = 2'd3;

  logic        i_sys_clk;
  logic        i_reset;
  logic        i_filter_busy;
  logic [31:0] o_afmr1, o_afmr2, o_afmr3, o_afmr4;
  logic [31:0] o_afir1, o_afir2, o_afir3, o_afir4;
  logic        o_uaf1, o_uaf2, o_uaf3, o_uaf4;
  logic        o_acfbsy;
  logic [1:0]  o_fsm_state;

  acceptance_filter_config_if bus ();

  acceptance_filter_config #(.SETTLE_CYCLES(2)) dut (
    .i_sys_clk    (i_sys_clk),
    .i_reset      (i_reset),
    .bus          (bus.slave),
    .i_filter_busy(i_filter_busy),
    .o_afmr1      (o_afmr1),
    .o_afmr2      (o_afmr2),
    .o_afmr3      (o_afmr3),
    .o_afmr4      (o_afmr4),
    .o_afir1      (o_afir1),
    .o_afir2      (o_afir2),
    .o_afir3      (o_afir3),
    .o_afir4      (o_afir4),
    .o_uaf1       (o_uaf1),
    .o_uaf2       (o_uaf2),
    .o_uaf3       (o_uaf3),
    .o_uaf4       (o_uaf4),
    .o_acfbsy     (o_acfbsy),
    .o_fsm_state  (o_fsm_state)
  );

  // clock / reset
  initial i_sys_clk = 1'b0;
  always #5 i_sys_clk = ~i_sys_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge i_sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_write(input string tag, input logic [3:0] addr, input logic [31:0] data,
                          input logic exp_ack);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = addr;
    bus.i_wr_data = data;
    tick();
    bus.i_wr_en = 1'b0;
    check({tag, "_ack"}, {31'd0, bus.o_wr_ack}, {31'd0, exp_ack});
    check({tag, "_err"}, {31'd0, bus.o_wr_err}, {31'd0, !exp_ack});
    tick();
    check({tag, "_pulse"}, {30'd0, bus.o_wr_ack, bus.o_wr_err}, 32'd0);
  endtask

  // scoreboard: expected read data pushed when the read is issued, popped when o_rd_valid appears
  task automatic do_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = addr;
    tick();
    bus.i_rd_en = 1'b0;
    check({tag, "_valid"}, {31'd0, bus.o_rd_valid}, 32'd1);
    if (bus.o_rd_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, bus.o_rd_data, e);
    end
  endtask

  initial begin
    int acks;
    logic got_ack;
    bus.i_wr_en = 1'b0; bus.i_wr_addr = 4'd0; bus.i_wr_data = 32'd0;
    bus.i_rd_en = 1'b0; bus.i_rd_addr = 4'd0;
    i_filter_busy = 1'b0;
    i_reset = 1'b1;
    tick(); tick();
    check("rst_state",  {30'd0, o_fsm_state}, {30'd0, S_IDLE});
    check("rst_flags",  {27'd0, bus.o_wr_ack, bus.o_wr_err, bus.o_rd_valid, o_acfbsy, o_uaf1}, 32'd0);
    check("rst_rddata", bus.o_rd_data, 32'd0);
    check("rst_afmr1",  o_afmr1, 32'd0);
    i_reset = 1'b0;
    tick();

    // plain register writes and reads
    do_write("w_afmr1", 4'd1, 32'hFFE0_0000, 1'b1);
    do_write("w_afir1", 4'd5, 32'h1230_0000, 1'b1);
    check("afmr1_hold", o_afmr1, 32'hFFE0_0000);
    check("afir1_hold", o_afir1, 32'h1230_0000);
    do_read("r_afmr1", 4'd1, 32'hFFE0_0000);
    do_read("r_afir1", 4'd5, 32'h1230_0000);
    do_read("r_afr0",  4'd0, 32'd0);
    do_read("r_inv12", 4'd12, 32'd0);

    // read and write the same address together: read sees the old value
    exp_q.push_back(32'd0);
    bus.i_rd_en = 1'b1; bus.i_rd_addr = 4'd2;
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd2; bus.i_wr_data = 32'h0000_0005;
    tick();
    bus.i_rd_en = 1'b0; bus.i_wr_en = 1'b0;
    check("rw_ack", {31'd0, bus.o_wr_ack}, 32'd1);
    check("rw_valid", {31'd0, bus.o_rd_valid}, 32'd1);
    check("rw_old", bus.o_rd_data, exp_q.pop_front());
    tick();
    check("afmr2_new", o_afmr2, 32'h0000_0005);

    // AFR = 1 with the filter idle
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd0; bus.i_wr_data = 32'h0000_0001;
    tick();                                   // E0
    bus.i_wr_en = 1'b0;
    check("afr1_e0_state", {30'd0, o_fsm_state}, {30'd0, S_WAIT});
    check("afr1_e0_bsy",   {30'd0, o_acfbsy, bus.o_wr_ack}, 32'd2);
    tick();                                   // E1
    check("afr1_e1_state", {30'd0, o_fsm_state}, {30'd0, S_APPLY});
    check("afr1_e1_uaf",   {31'd0, o_uaf1}, 32'd0);
    tick();                                   // E2
    check("afr1_e2_state", {30'd0, o_fsm_state}, {30'd0, S_SETTLE});
    check("afr1_e2_uaf",   {31'd0, o_uaf1}, 32'd1);
    i_filter_busy = 1'b1;                     // busy rising in SETTLE must not matter
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd6; bus.i_wr_data = 32'h1111_1111;
    tick();                                   // E3
    bus.i_wr_en = 1'b0;
    check("afr1_e3_err",   {30'd0, bus.o_wr_err, bus.o_wr_ack}, 32'd2);
    check("afr1_e3_bsy",   {31'd0, o_acfbsy}, 32'd1);
    tick();                                   // E4
    check("afr1_e4_ack",   {30'd0, bus.o_wr_ack, bus.o_wr_err}, 32'd2);
    check("afr1_e4_bsy",   {31'd0, o_acfbsy}, 32'd0);
    check("afr1_e4_state", {30'd0, o_fsm_state}, {30'd0, S_IDLE});
    i_filter_busy = 1'b0;
    tick();
    check("afr1_ack_pulse", {31'd0, bus.o_wr_ack}, 32'd0);
    check("afir2_unchanged", o_afir2, 32'd0);

    // pair 1 is locked while UAF1 = 1
    do_write("w_afir1_locked", 4'd5, 32'hAAAA_0000, 1'b0);
    check("afir1_kept", o_afir1, 32'h1230_0000);
    do_write("w_afmr1_locked", 4'd1, 32'h0, 1'b0);
    do_write("w_afir2", 4'd6, 32'hAAAA_0000, 1'b1);
    check("afir2_new", o_afir2, 32'hAAAA_0000);
    do_read("r_afr_1", 4'd0, 32'd1);

    // AFR = 0 while the filter is busy
    i_filter_busy = 1'b1;
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd0; bus.i_wr_data = 32'h0;
    tick();
    bus.i_wr_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("wait_state", {30'd0, o_fsm_state}, {30'd0, S_WAIT});
      check("wait_uaf1",  {30'd0, o_uaf1, o_acfbsy}, 32'd3);
      tick();
    end
    do_write("w_during_wait", 4'd7, 32'h7777_7777, 1'b0);
    do_read("r_during_wait", 4'd0, 32'd1);
    check("afir3_untouched", o_afir3, 32'd0);
    i_filter_busy = 1'b0;
    tick();
    check("busy_fall_state", {30'd0, o_fsm_state}, {30'd0, S_APPLY});
    check("busy_fall_uaf1",  {31'd0, o_uaf1}, 32'd1);
    tick();
    check("applied_uaf1", {31'd0, o_uaf1}, 32'd0);
    got_ack = 1'b0;
    for (int i = 0; i < 10 && !got_ack; i++) begin
      tick();
      if (bus.o_wr_ack) got_ack = 1'b1;
    end
    check("afr0_ack_seen", {31'd0, got_ack}, 32'd1);

    do_write("w_inv12", 4'd12, 32'h1, 1'b0);
    do_write("w_afir1_unlocked", 4'd5, 32'hAAAA_0000, 1'b1);
    check("afir1_new", o_afir1, 32'hAAAA_0000);

    // reset in the middle of SETTLE
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'd0; bus.i_wr_data = 32'h0000_000F;
    tick();
    bus.i_wr_en = 1'b0;
    tick(); tick();
    check("pre_rst_state", {30'd0, o_fsm_state}, {30'd0, S_SETTLE});
    check("pre_rst_uaf",   {28'd0, o_uaf4, o_uaf3, o_uaf2, o_uaf1}, 32'hF);
    i_reset = 1'b1;
    #1;
    check("async_rst_uaf",   {28'd0, o_uaf4, o_uaf3, o_uaf2, o_uaf1}, 32'd0);
    check("async_rst_state", {30'd0, o_fsm_state}, {30'd0, S_IDLE});
    check("async_rst_bsy",   {31'd0, o_acfbsy}, 32'd0);
    check("async_rst_regs",  o_afmr1 | o_afmr2 | o_afir1 | o_afir2, 32'd0);
    tick(); tick();
    i_reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.o_wr_ack) acks++;
    end
    check("no_ack_after_rst", acks, 32'd0);
    do_write("w_addr12", 4'd12, 32'h5, 1'b0);
    do_read("r_afr_after_rst", 4'd0, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/acceptance_filter_config.md
ACCEPTANCE_FILTER_CONFIG -- requirements
Module: acceptance_filter_config

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2: cycles o_acfbsy is held after a new UAF value is applied (1..15).
REQ-002 i_sys_clk  in  1  system clock; all logic rising-edge.
REQ-003 i_reset  in  1  reset, asynchronous, active-high.
REQ-004 i_wr_en  in  1  single-cycle register write strobe.
REQ-005 i_wr_addr  in  4  write address: 0=AFR, 1..4=AFMR1..4, 5..8=AFIR1..4, 9..15 invalid.
REQ-006 i_wr_data  in  32  write data; for AFR only bits [3:0] (UAF4..UAF1) used.
REQ-007 o_wr_ack  out  1  one-cycle pulse, write completed.
REQ-008 o_wr_err  out  1  one-cycle pulse, write rejected; no state changed.
REQ-009 i_rd_en / i_rd_addr  in  1/4  read strobe and address, same map.
REQ-010 o_rd_data / o_rd_valid  out  32/1  read data and one-cycle valid.
REQ-011 i_filter_busy  in  1  filter is evaluating or writing a message.
REQ-012 o_afmr1..o_afmr4, o_afir1..o_afir4  out  32 each  mask/ID registers driven to the filter.
REQ-013 o_uaf1..o_uaf4  out  1 each  filter-pair enables driven to the filter.
REQ-014 o_acfbsy  out  1  filter configuration update in progress.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_FLT, APPLY, SETTLE.
REQ-016 Write in IDLE to AFMRx/AFIRx with UAFx=0 SHALL load i_wr_data at that edge and pulse o_wr_ack the following cycle; FSM stays IDLE.
REQ-017 Write to AFMRx/AFIRx while UAFx=1 SHALL be rejected: o_wr_err pulse the following cycle, register unchanged.
REQ-018 Write to invalid address (9..15) SHALL pulse o_wr_err the following cycle.
REQ-019 Any write while FSM not in IDLE SHALL pulse o_wr_err the following cycle and be discarded.
REQ-020 Write to AFR in IDLE SHALL capture i_wr_data[3:0] into a pending register, set o_acfbsy=1 at that edge, go to WAIT_FLT.
REQ-021 WAIT_FLT SHALL remain while i_filter_busy=1; when i_filter_busy=0, go to APPLY.
REQ-022 APPLY SHALL last one cycle, copy pending bits to o_uaf1..4, load settle counter with SETTLE_CYCLES, go to SETTLE.
REQ-023 SETTLE SHALL decrement counter each cycle; at count 1 go to IDLE, clear o_acfbsy and pulse o_wr_ack on the same edge.
REQ-024 AFR write latency with filter idle SHALL therefore be 3+SETTLE_CYCLES cycles from i_wr_en to o_wr_ack.
REQ-025 AFR write with value equal to current UAF SHALL still traverse the full sequence.
REQ-026 o_uaf1..4 SHALL change only in APPLY; o_afmr/o_afir SHALL change only per REQ-016.
REQ-027 Reads SHALL be served in any state: o_rd_data/o_rd_valid registered, one cycle after i_rd_en; AFR reads return {28'b0, applied UAF}, invalid address returns 0.
REQ-028 Simultaneous read and write to the same address SHALL return the pre-write value.
REQ-029 o_wr_ack and o_wr_err SHALL never be high in the same cycle.
REQ-030 i_filter_busy rising during SETTLE SHALL not alter the sequence.

Reset
REQ-031 On i_reset=1 asynchronously: FSM=IDLE, all AFMR/AFIR=0, o_uaf1..4=0, pending=0, counter=0, o_acfbsy=0, o_wr_ack=0, o_wr_err=0, o_rd_valid=0, o_rd_data=0.
REQ-032 Reset mid-sequence (WAIT_FLT/APPLY/SETTLE) SHALL abort the AFR write with no o_wr_ack issued after release.

Verification
REQ-033 After reset, write AFMR1=0xFFE00000 then AFIR1=0x12300000 -> o_wr_ack each next cycle, o_afmr1/o_afir1 hold values, read addr 1 returns 0xFFE00000.
REQ-034 Write AFR=0x1 with i_filter_busy=0, SETTLE_CYCLES=2 -> o_acfbsy high 4 cycles, o_uaf1=1 after APPLY, o_wr_ack 5 cycles after i_wr_en.
REQ-035 With o_uaf1=1, write AFIR1=0xAAAA0000 -> o_wr_err pulse, o_afir1 unchanged; write AFIR2 accepted.
REQ-036 Write AFR=0x0 while i_filter_busy=1 for 10 cycles -> FSM in WAIT_FLT, o_uaf1 stays 1 until busy falls, then cleared in APPLY; write during WAIT_FLT -> o_wr_err.
REQ-037 Assert i_reset during SETTLE -> all outputs 0 immediately, no o_wr_ack after release; write to addr 12 -> o_wr_err.
